bpred_update_ctrl: RTL and testbench
====================================

// Module: bpred_update_ctrl
// PURPOSE
//  Write-side partner of the branch predictor update port (update_valid/eip/target/taken).
//  Collects resolved branches from execute and detects mispredictions.
//  Queues resolved branches and drains them to the predictor one per cycle under update_ready.
//  On a mispredict, raises a one-cycle front-end redirect.
// PARAMETERS
//  DEPTH   8   update queue entries, power of two, >=2
//  ADDR_W  32  PC / target width
// PORTS
//  CLK              in   1       clock, all state on posedge
//  reset            in   1       synchronous, active-low (0 = reset)
//  res_valid        in   1       resolved branch presented by execute
//  res_ready        out  1       queue can accept; = !full (registered count)
//  res_eip          in   ADDR_W  branch PC
//  res_target       in   ADDR_W  actual target
//  res_taken        in   1       actual direction
//  res_pred_taken   in   1       direction predicted at fetch
//  res_pred_target  in   ADDR_W  target predicted at fetch
//  update_valid     out  1       head entry valid toward predictor
//  update_eip       out  ADDR_W  head PC
//  update_target    out  ADDR_W  head actual target
//  update_taken     out  1       head actual direction
//  update_ready     in   1       predictor accepts update this cycle
//  redirect_valid   out  1       mispredict pulse, one cycle
//  redirect_pc      out  ADDR_W  correct fetch PC
//  q_count          out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  - Reset (reset==0 at posedge): q_count=0, rd/wr ptrs=0, update_valid=0, update_* =0,
//    redirect_valid=0, redirect_pc=0. Reset mid-drain discards all entries, no update emitted.
//  - Accept: res_valid && res_ready at posedge -> entry written at wr_ptr; wr_ptr wraps mod DEPTH.
//  - Drain: update_valid = (q_count!=0); update_* driven from head entry (queue RAM read, no comb
//    path from res_* to update_*). update_valid && update_ready -> rd_ptr++ (wrap mod DEPTH).
//  - Latency: entry accepted at edge N is visible on update_* from cycle N+1 if queue was empty.
//  - Simultaneous accept+drain: count unchanged; when empty, accepted entry not bypassed (N+1 rule).
//  - Full: res_ready=0 even if a drain occurs same cycle; res_valid ignored.
//  - update_ready low: head held stable, update_valid stays 1 (must not drop while pending).
//  - Mispredict = res_taken!=res_pred_taken || (res_taken && res_target!=res_pred_target).
//  - Evaluated only on accept; redirect_valid=1 in cycle N+1 for exactly one cycle,
//    redirect_pc = res_taken ? res_target : res_eip+4 (mod 2^ADDR_W, wrap allowed).
//  - Back-to-back mispredicts give back-to-back pulses; each carries its own PC.
//  - Redirect never flushes the queue: resolved branches are architecturally valid training data.
//  - Not-taken entries still carry res_target unmodified on update_target.
// CONFIGURATION
//  BPRED_UPD_FILTER_EN defined: accepted branches with res_taken==0 && res_pred_taken==0
//    are NOT enqueued (res_ready still = !full); mispredict/redirect logic unchanged.
//  Undefined: every accepted branch is enqueued.
// STRUCTURE
//  bpred_pkg: ADDR_W default, bpred_upd_t {eip, target, taken} typedef, CNT_W function.
//  Sub-module bpred_upd_fifo (DEPTH, entry type): storage, ptrs, count, full/empty.
//  Top holds mispredict compare, redirect register, filter gating.
// TESTING
//  1 reset held 2 cycles with res_valid=1 -> q_count=0, update_valid=0, redirect_valid=0.
//  2 accept eip=16 tgt=45 taken=1 pred_taken=1 pred_tgt=45, update_ready=1
//    -> next cycle update_valid=1 eip=16 tgt=45 taken=1; redirect_valid stays 0.
//  3 accept eip=64 tgt=25 taken=0 pred_taken=1 -> next cycle redirect_valid=1 pc=68,
//    one cycle; update eip=64 taken=0 tgt=25.
//  4 update_ready=0, accept 8 branches -> q_count=8, res_ready=0, 9th ignored;
//    release ready -> 8 updates in order on consecutive cycles, eips match, ptr wrap exercised.
//  5 eip=0xFFFFFFFC taken=0 pred_taken=1 -> redirect_pc=0 (wrap).
//  6 BPRED_UPD_FILTER_EN: correct not-taken eip=32 accepted -> q_count unchanged,
//    no update; without macro -> update eip=32 taken=0.

Source files
------------

// File: rtl/bpred_pkg.sv
// Shared types and sizing helpers for the branch predictor update path.
package bpred_pkg;

  localparam int BPRED_ADDR_W = 32;

  // Default-width update record; wider/narrower instances build their own.
  typedef struct packed {
    logic [BPRED_ADDR_W-1:0] eip;
    logic [BPRED_ADDR_W-1:0] target;
    logic                    taken;
  } bpred_upd_t;

  function automatic int CNT_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bpred_upd_fifo.sv
// Update queue: power-of-two ring buffer with registered occupancy count.
module bpred_upd_fifo
  import bpred_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = bpred_upd_t
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  entry_t                    wr_data,
  input  logic                      rd_en,
  output entry_t                    rd_data,
  output logic [CNT_W(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_wr;
  logic               do_rd;

  assign full    = (count == CNT_W(DEPTH)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  // Empty queue presents zeros so stale RAM contents never leak out.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W(DEPTH)'(1);
        2'b01:   count <= count - CNT_W(DEPTH)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity lives in the count and pointers.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/bpred_update_ctrl.sv
// Branch predictor update controller: queues resolved branches, drains them to the
// predictor, and pulses a front-end redirect on mispredict. Optional: BPRED_UPD_FILTER_EN.
module bpred_update_ctrl
  import bpred_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = BPRED_ADDR_W
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [ADDR_W-1:0]        res_eip,
  input  logic [ADDR_W-1:0]        res_target,
  input  logic                     res_taken,
  input  logic                     res_pred_taken,
  input  logic [ADDR_W-1:0]        res_pred_target,
  output logic                     update_valid,
  output logic [ADDR_W-1:0]        update_eip,
  output logic [ADDR_W-1:0]        update_target,
  output logic                     update_taken,
  input  logic                     update_ready,
  output logic                     redirect_valid,
  output logic [ADDR_W-1:0]        redirect_pc,
  output logic [CNT_W(DEPTH)-1:0]  q_count
);

  typedef struct packed {
    logic [ADDR_W-1:0] eip;
    logic [ADDR_W-1:0] target;
    logic              taken;
  } upd_t;

  upd_t        wr_entry;
  upd_t        head;
  logic        full;
  logic        empty;
  logic        accept;
  logic        enqueue;
  logic        mispredict;
  logic [ADDR_W-1:0] correct_pc;

  assign res_ready = !full;
  assign accept    = res_valid && res_ready;
  assign wr_entry  = '{eip: res_eip, target: res_target, taken: res_taken};

`ifdef BPRED_UPD_FILTER_EN
  // Correctly predicted not-taken branches carry no training value.
  assign enqueue = accept && (res_taken || res_pred_taken);
`else
  assign enqueue = accept;
`endif

  always_comb begin
    mispredict = (res_taken != res_pred_taken) ||
                 (res_taken && (res_target != res_pred_target));
    correct_pc = res_taken ? res_target : res_eip + ADDR_W'(4);
  end

  bpred_upd_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (upd_t)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (reset),
    .wr_en   (enqueue),
    .wr_data (wr_entry),
    .rd_en   (update_ready),
    .rd_data (head),
    .count   (q_count),
    .full    (full),
    .empty   (empty)
  );

  assign update_valid  = !empty;
  assign update_eip    = head.eip;
  assign update_target = head.target;
  assign update_taken  = head.taken;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= accept && mispredict;
      if (accept && mispredict) redirect_pc <= correct_pc;
    end
  end

endmodule

// File: tb/tb_bpred_update_ctrl.sv
// Directed self-checking bench for bpred_update_ctrl (honours BPRED_UPD_FILTER_EN).
module tb_bpred_update_ctrl;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              res_valid;
  logic              res_ready;
  logic [ADDR_W-1:0] res_eip;
  logic [ADDR_W-1:0] res_target;
  logic              res_taken;
  logic              res_pred_taken;
  logic [ADDR_W-1:0] res_pred_target;
  logic              update_valid;
  logic [ADDR_W-1:0] update_eip;
  logic [ADDR_W-1:0] update_target;
  logic              update_taken;
  logic              update_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CW-1:0]     q_count;

  int checks = 0;
  int errors = 0;

  bpred_update_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK             (clk),
    .reset           (reset),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_eip         (res_eip),
    .res_target      (res_target),
    .res_taken       (res_taken),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .update_valid    (update_valid),
    .update_eip      (update_eip),
    .update_target   (update_target),
    .update_taken    (update_taken),
    .update_ready    (update_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .q_count         (q_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] eip, input logic [31:0] tgt,
                       input logic tk, input logic ptk, input logic [31:0] ptgt);
    res_valid       = v;
    res_eip         = eip;
    res_target      = tgt;
    res_taken       = tk;
    res_pred_taken  = ptk;
    res_pred_target = ptgt;
  endtask

  initial begin
    reset        = 1'b0;
    update_ready = 1'b1;
    drive(1'b1, 32'h10, 32'h2D, 1'b1, 1'b1, 32'h2D);

    // 1: reset held two cycles with res_valid asserted
    tick(); tick();
    check("rst_q_count", 64'(q_count), 64'd0);
    check("rst_update_valid", 64'(update_valid), 64'd0);
    check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    check("rst_update_eip", 64'(update_eip), 64'd0);
    reset = 1'b1;

    // 2: correctly predicted taken branch, visible next cycle
    drive(1'b1, 32'd16, 32'd45, 1'b1, 1'b1, 32'd45);
    tick();
    check("t2_update_valid", 64'(update_valid), 64'd1);
    check("t2_update_eip", 64'(update_eip), 64'd16);
    check("t2_update_target", 64'(update_target), 64'd45);
    check("t2_update_taken", 64'(update_taken), 64'd1);
    check("t2_redirect_valid", 64'(redirect_valid), 64'd0);
    check("t2_q_count", 64'(q_count), 64'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    check("t2_drained", 64'(q_count), 64'd0);

    // 3: direction mispredict, predicted taken but not taken
    drive(1'b1, 32'd64, 32'd25, 1'b0, 1'b1, 32'd25);
    tick();
    check("t3_redirect_valid", 64'(redirect_valid), 64'd1);
    check("t3_redirect_pc", 64'(redirect_pc), 64'd68);
    check("t3_update_eip", 64'(update_eip), 64'd64);
    check("t3_update_taken", 64'(update_taken), 64'd0);
    check("t3_update_target", 64'(update_target), 64'd25);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    check("t3_redirect_pulse_end", 64'(redirect_valid), 64'd0);
    check("t3_q_count", 64'(q_count), 64'd0);

    // 4: fill with predictor stalled (pointers start at 2, so they wrap)
    update_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'(100 + 4 * i), 32'(500 + i), 1'b1, 1'b1, 32'(500 + i));
      tick();
    end
    check("t4_q_count_full", 64'(q_count), 64'd8);
    check("t4_res_ready_full", 64'(res_ready), 64'd0);
    check("t4_head_held", 64'(update_eip), 64'd100);
    check("t4_valid_held", 64'(update_valid), 64'd1);
    drive(1'b1, 32'd999, 32'd999, 1'b1, 1'b1, 32'd999);
    tick();
    check("t4_ninth_ignored", 64'(q_count), 64'd8);
    check("t4_stall_no_redirect", 64'(redirect_valid), 64'd0);
    // Release: first drain cycle still full, so 999 must be refused.
    update_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("t4_drain_ready_low", 64'(res_ready), (i == 0) ? 64'd0 : 64'd1);
      check("t4_drain_valid", 64'(update_valid), 64'd1);
      check("t4_drain_eip", 64'(update_eip), 64'(100 + 4 * i));
      check("t4_drain_target", 64'(update_target), 64'(500 + i));
      tick();
      if (i == 0) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    end
    check("t4_drained_valid", 64'(update_valid), 64'd0);
    check("t4_drained_count", 64'(q_count), 64'd0);

    // 5: fall-through wrap, then a back-to-back target mispredict
    drive(1'b1, 32'hFFFF_FFFC, 32'h1234, 1'b0, 1'b1, 32'h1234);
    tick();
    check("t5_redirect_valid", 64'(redirect_valid), 64'd1);
    check("t5_redirect_pc_wrap", 64'(redirect_pc), 64'd0);
    drive(1'b1, 32'h200, 32'h300, 1'b1, 1'b1, 32'h304);
    tick();
    check("t5_b2b_valid", 64'(redirect_valid), 64'd1);
    check("t5_b2b_pc", 64'(redirect_pc), 64'h300);
    check("t5_b2b_update_eip", 64'(update_eip), 64'h200);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    check("t5_pulse_end", 64'(redirect_valid), 64'd0);
    check("t5_empty", 64'(q_count), 64'd0);

    // 6: correctly predicted not-taken branch
    drive(1'b1, 32'd32, 32'h40, 1'b0, 1'b0, 32'h40);
    tick();
    check("t6_redirect_valid", 64'(redirect_valid), 64'd0);
`ifdef BPRED_UPD_FILTER_EN
    check("t6_filtered_count", 64'(q_count), 64'd0);
    check("t6_filtered_valid", 64'(update_valid), 64'd0);
`else
    check("t6_update_valid", 64'(update_valid), 64'd1);
    check("t6_update_eip", 64'(update_eip), 64'd32);
    check("t6_update_taken", 64'(update_taken), 64'd0);
    check("t6_update_target", 64'(update_target), 64'h40);
`endif
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();

    // 7: reset mid-drain discards the queue
    update_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(700 + 4 * i), 32'd1, 1'b1, 1'b1, 32'd1);
      tick();
    end
    check("t7_q_count", 64'(q_count), 64'd3);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    update_ready = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t7_rst_count", 64'(q_count), 64'd0);
    check("t7_rst_valid", 64'(update_valid), 64'd0);
    check("t7_rst_eip", 64'(update_eip), 64'd0);
    tick();
    check("t7_stays_empty", 64'(update_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
